bcd_to_signed_bin: RTL

- Sequential converter from four BCD digits plus a sign flag to a 17-bit two's-complement binary value.
- It is the inverse of the display path, which turns a signed 17-bit value into four decimal digits and a minus indicator.
- Used wherever a decimal entry (score presets, threshold/offset settings) must be turned back into the binary values the game logic uses.
- Multiply-by-10-and-add, one digit per clock, start/done handshake.

---
 rtl/bcd_to_signed_bin_pkg.sv | 7 +
 rtl/bcd_to_signed_bin_if.sv | 15 +
 rtl/bcd_to_signed_bin_mac10.sv | 12 +
 rtl/bcd_to_signed_bin.sv | 90 +++++++++
 4 files changed

// File: rtl/bcd_to_signed_bin_pkg.sv
// bcd_to_signed_bin_pkg: shared types and range constants for the decimal <-> binary paths.
package bcd_to_signed_bin_pkg;
   typedef enum logic [1:0] {IDLE, ACCUM, FINISH} state_t;
   localparam int BCD_MAX = 9;
   localparam int DISPLAY_DIGITS = 4;
   localparam int VAL_WIDTH = 17;
endpackage

// File: rtl/bcd_to_signed_bin_if.sv
// bcd_to_signed_bin_if: start/done request bus carrying BCD digits in and a signed value out.
interface bcd_to_signed_bin_if #(
   parameter int NUM_DIGITS = bcd_to_signed_bin_pkg::DISPLAY_DIGITS,
   parameter int WIDTH = bcd_to_signed_bin_pkg::VAL_WIDTH
);
   logic start;
   logic [4*NUM_DIGITS-1:0] digits;
   logic neg;
   logic busy;
   logic done;
   logic [WIDTH-1:0] val;
   logic err;
   modport master (output start, digits, neg, input busy, done, val, err);
   modport slave (input start, digits, neg, output busy, done, val, err);
endinterface

// File: rtl/bcd_to_signed_bin_mac10.sv
// bcd_mac10: combinational acc*10 + digit, flagging digits outside 0..9.
module bcd_mac10 import bcd_to_signed_bin_pkg::*; #(
   parameter int AW = VAL_WIDTH - 1
) (
   input  logic [AW-1:0] acc,
   input  logic [3:0]    digit,
   output logic [AW-1:0] sum,
   output logic          bad
);
   assign sum = (acc << 3) + (acc << 1) + AW'(digit);
   assign bad = digit > 4'(BCD_MAX);
endmodule

// File: rtl/bcd_to_signed_bin.sv
// bcd_to_signed_bin: sequential BCD-to-signed-binary converter, one digit per clock, MS digit first.
module bcd_to_signed_bin import bcd_to_signed_bin_pkg::*; #(
   parameter int NUM_DIGITS = DISPLAY_DIGITS,
   parameter int WIDTH = VAL_WIDTH
) (
   input logic clk,
   input logic rst,
   bcd_to_signed_bin_if.slave b
);
   localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
   localparam int AW = WIDTH - 1;
   state_t state_q, state_d;
   logic [AW-1:0] acc_q, acc_d, mac_sum;
   logic [IW-1:0] idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] dig_q, dig_d;
   logic neg_q, neg_d, bad_q, bad_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic [WIDTH-1:0] val_q, val_d, mag;
   logic [3:0] cur;
   logic cur_bad;
   assign cur = 4'(dig_q >> {idx_q, 2'b00});
   assign mag = {1'b0, acc_q};
   bcd_mac10 #(.AW(AW)) u_mac (.acc(acc_q), .digit(cur), .sum(mac_sum), .bad(cur_bad));
   always_comb begin
      state_d = state_q;
      acc_d = acc_q;
      idx_d = idx_q;
      dig_d = dig_q;
      neg_d = neg_q;
      bad_d = bad_q;
      busy_d = busy_q;
      done_d = 1'b0;
      val_d = val_q;
      err_d = err_q;
      case (state_q)
         IDLE: if (b.start) begin
            state_d = ACCUM;
            dig_d = b.digits;
            neg_d = b.neg;
            acc_d = '0;
            idx_d = IW'(NUM_DIGITS - 1);
            bad_d = 1'b0;
            busy_d = 1'b1;
         end
         ACCUM: begin
            acc_d = mac_sum;
            bad_d = bad_q | cur_bad;
            idx_d = idx_q - 1'b1;
            state_d = idx_q == '0 ? FINISH : ACCUM;
         end
         FINISH: begin
            // an illegal digit anywhere discards the whole entry, sign included
            val_d = bad_q ? '0 : (neg_q ? -mag : mag);
            err_d = bad_q;
            done_d = 1'b1;
            busy_d = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q <= '0;
         idx_q <= '0;
         dig_q <= '0;
         neg_q <= 1'b0;
         bad_q <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         val_q <= '0;
         err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q <= acc_d;
         idx_q <= idx_d;
         dig_q <= dig_d;
         neg_q <= neg_d;
         bad_q <= bad_d;
         busy_q <= busy_d;
         done_q <= done_d;
         val_q <= val_d;
         err_q <= err_d;
      end
   end
   assign b.busy = busy_q;
   assign b.done = done_q;
   assign b.val = val_q;
   assign b.err = err_q;
endmodule
